// File: rtl/dest_reader.sv
// dest_reader: egress consumer for the D0/D1 destination FIFOs of the VC
// interconnect. It pops both FIFOs with round-robin arbitration and buffers
// the returned words in a 3-entry output FIFO. The result is one merged
// valid/ready stream, tagged with the destination each word came from.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// RD_IDLE    | no read issued last cycle, nothing to capture
// RD_WAIT_D0 | D0 was popped last cycle, D0_data_out is captured now
// RD_WAIT_D1 | D1 was popped last cycle, D1_data_out is captured now
module dest_reader #(
    parameter int BW    = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D0_empty,
    input  logic             D0_error_output,
    input  logic [BW-1:0]    D0_data_out,
    output logic             D0_rd,
    input  logic             D1_empty,
    input  logic             D1_error_output,
    input  logic [BW-1:0]    D1_data_out,
    output logic             D1_rd,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BW-1:0]    out_data,
    output logic             out_dest,
    output logic [CNT_W-1:0] D0_count,
    output logic [CNT_W-1:0] D1_count,
    output logic [1:0]       err_seen
);

    typedef enum logic [1:0] {
        RD_IDLE    = 2'd0,
        RD_WAIT_D0 = 2'd1,
        RD_WAIT_D1 = 2'd2
    } rd_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    rd_state_t       state;
    rd_state_t       state_nxt;
    logic            rr_ptr;        // destination preferred on the next tie
    logic            rd0;
    logic            rd1;
    logic            push;
    logic [BW-1:0]   push_data;
    logic            push_dest;
    logic            pop;
    logic            infl;
    logic            elig0;
    logic            elig1;
    logic            credit_ok;
    logic [2:0]      credit_lhs;
    logic [2:0]      credit_rhs;

    logic [BW-1:0]   buf_data [3];
    logic            buf_dest [3];
    logic [1:0]      head;
    logic [1:0]      tail;
    logic [1:0]      occ;
    logic [BW-1:0]   hold_data;     // last word handed out, shown while empty
    logic            hold_dest;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // A destination that has ever flagged an error is fenced off until reset.
    assign elig0 = ~D0_empty & ~D0_error_output & ~err_seen[0];
    assign elig1 = ~D1_empty & ~D1_error_output & ~err_seen[1];

    assign out_valid = (occ != 2'd0);
    assign out_data  = out_valid ? buf_data[head] : hold_data;
    assign out_dest  = out_valid ? buf_dest[head] : hold_dest;
    assign pop       = out_valid & out_ready;
    assign infl      = (state != RD_IDLE);

    // Issue a read only if the word can still fit once the in-flight word
    // lands; counting this cycle's pop keeps one word per cycle sustained.
    assign credit_lhs = {1'b0, occ} + {2'b00, infl};
    assign credit_rhs = 3'd3 + {2'b00, pop};
    assign credit_ok  = (credit_lhs < credit_rhs);

    assign D0_rd = rd0;
    assign D1_rd = rd1;

    // Read-tracking state and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= RD_IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (rd0) begin
                rr_ptr <= 1'b1;
            end else if (rd1) begin
                rr_ptr <= 1'b0;
            end
        end
    end

    // Capture of returning data, arbitration and next read-tracking state.
    always_comb begin
        state_nxt = RD_IDLE;
        rd0       = 1'b0;
        rd1       = 1'b0;
        push      = 1'b0;
        push_data = '0;
        push_dest = 1'b0;

        case (state)
            RD_WAIT_D0: begin
                push      = 1'b1;
                push_data = D0_data_out;
                push_dest = 1'b0;
            end
            RD_WAIT_D1: begin
                push      = 1'b1;
                push_data = D1_data_out;
                push_dest = 1'b1;
            end
            default: begin
                push = 1'b0;
            end
        endcase

        // Reset still has to take effect at the next edge, so no pops are
        // issued while it is high.
        if (!reset && credit_ok) begin
            if (elig0 && (!elig1 || !rr_ptr)) begin
                rd0       = 1'b1;
                state_nxt = RD_WAIT_D0;
            end else if (elig1) begin
                rd1       = 1'b1;
                state_nxt = RD_WAIT_D1;
            end
        end
    end

    // Output FIFO pointers, occupancy and the hold register for the idle bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            head      <= 2'd0;
            tail      <= 2'd0;
            occ       <= 2'd0;
            hold_data <= '0;
            hold_dest <= 1'b0;
        end else begin
            if (pop) begin
                head      <= ptr_inc(head);
                hold_data <= buf_data[head];
                hold_dest <= buf_dest[head];
            end
            if (push) begin
                tail <= ptr_inc(tail);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Output FIFO storage; contents are only observed through head when occ > 0.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            buf_data[tail] <= push_data;
            buf_dest[tail] <= push_dest;
        end
    end

    // Saturating delivered-word counters, bumped on each downstream handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            D0_count <= '0;
            D1_count <= '0;
        end else if (pop) begin
            if (!out_dest && (D0_count != CNT_MAX)) begin
                D0_count <= D0_count + 1'b1;
            end
            if (out_dest && (D1_count != CNT_MAX)) begin
                D1_count <= D1_count + 1'b1;
            end
        end
    end

    // Sticky per-destination error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_seen <= 2'b00;
        end else begin
            err_seen <= err_seen | {D1_error_output, D0_error_output};
        end
    end

endmodule

// File: tb/tb_dest_reader.sv
// Directed bench for dest_reader: behavioural D0/D1 FIFOs feed the DUT, a
// monitor logs grants and delivered words, and each test compares the logs
// against hand-computed sequences. A second instance with CNT_W = 2 covers
// counter saturation.
module tb_dest_reader;

    localparam int BW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          D0_empty, D0_error_output, D0_rd;
    logic [BW-1:0] D0_data_out;
    logic          D1_empty, D1_error_output, D1_rd;
    logic [BW-1:0] D1_data_out;
    logic          out_ready, out_valid, out_dest;
    logic [BW-1:0] out_data;
    logic [7:0]    D0_count, D1_count;
    logic [1:0]    err_seen;

    // saturation instance signals
    logic          s_reset;
    logic          s_empty, s_rd0, s_rd1, s_valid, s_dest;
    logic [BW-1:0] s_data;
    logic [1:0]    s_cnt0, s_cnt1, s_err;
    int            s_avail = 5;
    int            s_pops  = 0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // behavioural source FIFOs
    logic [BW-1:0] m0 [32];
    logic [BW-1:0] m1 [32];
    int w0 = 0, w1 = 0, r0 = 0, r1 = 0;
    logic flush1;

    // monitor logs
    logic [BW-1:0] cap_data [256];
    logic          cap_dest [256];
    int            cap_cyc  [256];
    int            n_cap = 0;
    logic          g_dest [256];
    int            g_cyc  [256];
    int            n_gnt = 0;
    int            n_rd1 = 0;
    int            n_both = 0;

    dest_reader #(.BW(BW), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .D0_empty(D0_empty), .D0_error_output(D0_error_output),
        .D0_data_out(D0_data_out), .D0_rd(D0_rd),
        .D1_empty(D1_empty), .D1_error_output(D1_error_output),
        .D1_data_out(D1_data_out), .D1_rd(D1_rd),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_dest(out_dest), .D0_count(D0_count), .D1_count(D1_count),
        .err_seen(err_seen)
    );

    dest_reader #(.BW(BW), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(s_reset),
        .D0_empty(s_empty), .D0_error_output(1'b0),
        .D0_data_out(6'h2A), .D0_rd(s_rd0),
        .D1_empty(1'b1), .D1_error_output(1'b0),
        .D1_data_out(6'h00), .D1_rd(s_rd1),
        .out_ready(1'b1), .out_valid(s_valid), .out_data(s_data),
        .out_dest(s_dest), .D0_count(s_cnt0), .D1_count(s_cnt1),
        .err_seen(s_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign D0_empty = (r0 >= w0);
    assign D1_empty = (r1 >= w1);
    assign s_empty  = (s_avail == 0);

    // D0 source model: read data appears the cycle after the pop request
    always @(posedge clk) begin
        if (D0_rd && !D0_empty) begin
            D0_data_out <= m0[r0];
            r0          <= r0 + 1;
        end
    end

    // D1 source model with a flush used between tests
    always @(posedge clk) begin
        if (flush1) begin
            r1 <= w1;
        end else if (D1_rd && !D1_empty) begin
            D1_data_out <= m1[r1];
            r1          <= r1 + 1;
        end
    end

    // feed for the saturation instance
    always @(posedge clk) begin
        if (s_rd0 && !s_empty) s_avail <= s_avail - 1;
    end

    // monitor: sample just before each rising edge
    always begin
        @(negedge clk);
        #4;
        if (out_valid && out_ready) begin
            if (n_cap < 256) begin
                cap_data[n_cap] = out_data;
                cap_dest[n_cap] = out_dest;
                cap_cyc[n_cap]  = cyc;
            end
            n_cap++;
        end
        if (D0_rd || D1_rd) begin
            if (n_gnt < 256) begin
                g_dest[n_gnt] = D1_rd;
                g_cyc[n_gnt]  = cyc;
            end
            n_gnt++;
        end
        if (D1_rd) n_rd1++;
        if (D0_rd && D1_rd) n_both++;
        if (s_valid) s_pops++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load0(input logic [BW-1:0] d);
        m0[w0] = d;
        w0++;
    endtask

    task automatic load1(input logic [BW-1:0] d);
        m1[w1] = d;
        w1++;
    endtask

    task automatic wait_caps(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while (n_cap < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        check(tag, n_cap, target);
    endtask

    task automatic check_caps(input string tag, input int base,
                              input logic [BW-1:0] d [5], input logic dst [5], input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, cap_data[base + i], d[i]);
            check({tag, "_dest"}, cap_dest[base + i], dst[i]);
        end
    endtask

    initial begin
        int cb, gb, rb;
        logic [BW-1:0] ed [5];
        logic          es [5];

        reset           = 1'b1;
        s_reset         = 1'b1;
        out_ready       = 1'b1;
        D0_error_output = 1'b0;
        D1_error_output = 1'b0;
        flush1          = 1'b0;

        // test 1: reset state, then two words from D0 only
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_cnt0", D0_count, 0);
        check("rst_cnt1", D1_count, 0);
        check("rst_err", err_seen, 0);
        check("rst_rd", {D1_rd, D0_rd}, 0);
        cb = n_cap; gb = n_gnt;
        load0(6'h05); load0(6'h17);
        reset = 1'b0; s_reset = 1'b0;
        wait_caps("t1_ncap", cb + 2, 20);
        check("t1_ngnt", n_gnt - gb, 2);
        check("t1_g0", g_dest[gb], 0);
        check("t1_g1", g_dest[gb + 1], 0);
        check("t1_rd_consec", g_cyc[gb + 1] - g_cyc[gb], 1);
        check("t1_latency", cap_cyc[cb] - g_cyc[gb], 2);
        check("t1_back2back", cap_cyc[cb + 1] - cap_cyc[cb], 1);
        ed = '{6'h05, 6'h17, 0, 0, 0}; es = '{0, 0, 0, 0, 0};
        check_caps("t1", cb, ed, es, 2);
        @(negedge clk); #1;
        check("t1_cnt0", D0_count, 2);
        check("t1_valid_idle", out_valid, 0);
        check("t1_hold_data", out_data, 6'h17);

        // test 2: both FIFOs loaded, round-robin alternation
        @(negedge clk);
        reset = 1'b1;
        load0(6'h01); load0(6'h02); load1(6'h21); load1(6'h22);
        repeat (2) @(negedge clk);
        cb = n_cap; gb = n_gnt;
        reset = 1'b0;
        wait_caps("t2_ncap", cb + 4, 30);
        check("t2_ngnt", n_gnt - gb, 4);
        for (int i = 0; i < 4; i++) check("t2_grant", g_dest[gb + i], i % 2);
        ed = '{6'h01, 6'h21, 6'h02, 6'h22, 0}; es = '{0, 1, 0, 1, 0};
        check_caps("t2", cb, ed, es, 4);
        @(negedge clk); #1;
        check("t2_cnt0", D0_count, 2);
        check("t2_cnt1", D1_count, 2);

        // test 3: back-pressure with five words available
        @(negedge clk);
        reset = 1'b1;
        out_ready = 1'b0;
        load0(6'h31); load0(6'h32); load0(6'h33); load1(6'h34); load1(6'h35);
        repeat (2) @(negedge clk);
        cb = n_cap; gb = n_gnt;
        reset = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("t3_ngnt_stall", n_gnt - gb, 3);
        check("t3_valid", out_valid, 1);
        check("t3_head_data", out_data, 6'h31);
        check("t3_head_dest", out_dest, 0);
        repeat (3) @(negedge clk);
        #1;
        check("t3_stable_data", out_data, 6'h31);
        check("t3_ngnt_still", n_gnt - gb, 3);
        check("t3_rd_low", {D1_rd, D0_rd}, 0);
        out_ready = 1'b1;
        wait_caps("t3_ncap", cb + 5, 30);
        check("t3_ngnt_total", n_gnt - gb, 5);
        ed = '{6'h31, 6'h34, 6'h32, 6'h35, 6'h33}; es = '{0, 1, 0, 1, 0};
        check_caps("t3", cb, ed, es, 5);
        @(negedge clk); #1;
        check("t3_cnt0", D0_count, 3);
        check("t3_cnt1", D1_count, 2);

        // test 4: D1 error pulse while D1 holds words
        @(negedge clk);
        reset = 1'b1;
        load1(6'h11); load1(6'h12); load1(6'h13); load0(6'h01); load0(6'h02);
        repeat (2) @(negedge clk);
        cb = n_cap; rb = n_rd1;
        reset = 1'b0;
        D1_error_output = 1'b1;
        @(negedge clk);
        D1_error_output = 1'b0;
        #1;
        check("t4_err_latch", err_seen, 2'b10);
        wait_caps("t4_ncap", cb + 2, 20);
        repeat (5) @(negedge clk);
        #1;
        check("t4_err_sticky", err_seen, 2'b10);
        check("t4_no_d1_rd", n_rd1 - rb, 0);
        check("t4_d1_nonempty", D1_empty, 0);
        ed = '{6'h01, 6'h02, 0, 0, 0}; es = '{0, 0, 0, 0, 0};
        check_caps("t4", cb, ed, es, 2);
        check("t4_cnt0", D0_count, 2);
        check("t4_cnt1", D1_count, 0);

        // test 5: reset the cycle after a D0 read drops the returning word
        flush1 = 1'b1;
        @(negedge clk);
        flush1 = 1'b0;
        @(negedge clk);
        cb = n_cap;
        load0(6'h3A);
        #1;
        check("t5_rd_issued", D0_rd, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("t5_valid", out_valid, 0);
        check("t5_cnt0", D0_count, 0);
        check("t5_cnt1", D1_count, 0);
        check("t5_err", err_seen, 0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("t5_dropped", n_cap - cb, 0);
        check("t5_valid_after", out_valid, 0);

        // test 6: CNT_W = 2 instance saturates at 3 after five words
        check("t6_pops", s_pops, 5);
        check("t6_sat", s_cnt0, 3);
        check("t6_cnt1", s_cnt1, 0);
        check("one_hot_rd", n_both, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
